// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider with lock delay, per-channel glitch-free
// enable, one-cycle clock-enable strobes and a valid/ready divisor update port.
module clk_div_multi #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DIV_RESET   = 4,
    parameter int LOCK_CYCLES = 256,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] ce_out,
    output logic              locked
);

    localparam int LOCK_W = $clog2(LOCK_CYCLES) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state    [NUM_CH];
    logic [DIV_W-1:0]   cnt      [NUM_CH];
    logic [DIV_W-1:0]   div_act  [NUM_CH];
    logic [DIV_W-1:0]   pend_div [NUM_CH];
    logic [NUM_CH-1:0]  pending;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [DIV_W-1:0]   cfg_div_clamped;

    // Out-of-range channel selects are always ready so the request is swallowed.
    always_comb begin
        cfg_div_clamped = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
        cfg_ready       = 1'b1;
        if (int'(cfg_ch) < NUM_CH)
            cfg_ready = !pending[cfg_ch];
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (!locked) begin
            lock_cnt <= lock_cnt + LOCK_W'(1);
            if (lock_cnt == LOCK_W'(LOCK_CYCLES - 1))
                locked <= 1'b1;
        end
    end

    // Accept only sets pending when it is clear, and starts/boundaries only clear
    // it when it is set, so both updates to pending[i] never collide on one edge.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            clk_out <= '0;
            ce_out  <= '0;
            pending <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                state[i]    <= IDLE;
                cnt[i]      <= '0;
                div_act[i]  <= DIV_W'(DIV_RESET);
                pend_div[i] <= DIV_W'(DIV_RESET);
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (cfg_valid && cfg_ready && int'(cfg_ch) == int'(i)) begin
                    pending[i]  <= 1'b1;
                    pend_div[i] <= cfg_div_clamped;
                end
                case (state[i])
                    IDLE: begin
                        clk_out[i] <= 1'b0;
                        ce_out[i]  <= 1'b0;
                        if (locked && en[i]) begin
                            state[i]   <= RUN;
                            cnt[i]     <= '0;
                            clk_out[i] <= 1'b1;
                            ce_out[i]  <= 1'b1;
                            if (pending[i]) begin
                                div_act[i] <= pend_div[i];
                                pending[i] <= 1'b0;
                            end
                        end
                    end
                    RUN: begin
                        if (cnt[i] != div_act[i] - DIV_W'(1)) begin
                            cnt[i]     <= cnt[i] + DIV_W'(1);
                            clk_out[i] <= (cnt[i] + DIV_W'(1)) < (div_act[i] >> 1);
                            ce_out[i]  <= 1'b0;
                        end else begin
                            cnt[i]     <= '0;
                            clk_out[i] <= en[i];
                            ce_out[i]  <= en[i];
                            if (!en[i])
                                state[i] <= IDLE;
                            if (pending[i]) begin
                                div_act[i] <= pend_div[i];
                                pending[i] <= 1'b0;
                            end
                        end
                    end
                    default: state[i] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: lock timing, waveform shapes per divisor,
// update handshake, enable drain and asynchronous reset.
module tb_clk_div_multi;

    logic       clk_in = 1'b0;
    logic       reset;
    logic [1:0] en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [1:0] clk_out;
    logic [1:0] ce_out;
    logic       locked;

    int tests = 0;
    int fails = 0;

    logic [31:0] cw, cev, rw;

    always #5 clk_in = ~clk_in;

    clk_div_multi #(
        .NUM_CH(2),
        .DIV_W(8),
        .DIV_RESET(4),
        .LOCK_CYCLES(256)
    ) dut (
        .clk_in(clk_in),
        .reset(reset),
        .en(en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch),
        .cfg_div(cfg_div),
        .clk_out(clk_out),
        .ce_out(ce_out),
        .locked(locked)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Samples the current negedge first, then advances; first sample ends up in the MSB.
    task automatic capture(input int ch, input int n,
                           output logic [31:0] c, output logic [31:0] e, output logic [31:0] r);
        c = '0; e = '0; r = '0;
        for (int k = 0; k < n; k++) begin
            c = {c[30:0], clk_out[ch]};
            e = {e[30:0], ce_out[ch]};
            r = {r[30:0], cfg_ready};
            @(negedge clk_in);
        end
    endtask

    task automatic sync_ce(input int ch);
        int k = 0;
        while (!ce_out[ch] && k < 40) begin
            @(negedge clk_in);
            k++;
        end
        check("sync_ce", 32'(ce_out[ch]), 32'd1);
    endtask

    task automatic wait_ready(input int ch);
        int k = 0;
        cfg_ch = 1'(ch);
        #1;
        while (!cfg_ready && k < 40) begin
            @(negedge clk_in);
            #1;
            k++;
        end
        check("wait_ready", 32'(cfg_ready), 32'd1);
    endtask

    task automatic wait_lock();
        int n = 0;
        while (!locked && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        check("lock_cycles", 32'(n), 32'd256);
    endtask

    task automatic cfg_write(input int ch, input int div);
        cfg_ch  = 1'(ch);
        cfg_div = 8'(div);
        #1;
        check("cfg_ready_before", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        @(negedge clk_in);
        cfg_valid = 1'b0;
    endtask

    task automatic lock_and_default_check();
        wait_lock();
        check("pre_rise_low", 32'(clk_out), 32'd0);
        @(negedge clk_in);
        check("first_rise_clk", 32'(clk_out), 32'd3);
        check("first_rise_ce", 32'(ce_out), 32'd3);
        capture(0, 8, cw, cev, rw);
        check("ch0_div4_clk", cw, 32'b11001100);
        check("ch0_div4_ce", cev, 32'b10001000);
        capture(1, 8, cw, cev, rw);
        check("ch1_div4_clk", cw, 32'b11001100);
        check("ch1_div4_ce", cev, 32'b10001000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; en = 2'b11; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
        #1;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_ce_out", 32'(ce_out), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        repeat (3) @(negedge clk_in);
        reset = 1'b0;
        lock_and_default_check();

        // ch0: switch 4 -> 10 while at cnt=1; current period still finishes
        @(negedge clk_in);
        check("ch0_cnt1_high", 32'(clk_out[0]), 32'd1);
        cfg_write(0, 10);
        capture(0, 13, cw, cev, rw);
        check("div10_clk", cw, 32'b0011111000001);
        check("div10_ce", cev, 32'b0010000000001);
        check("div10_ready", rw, 32'b0011111111111);

        // ch1: divisor 7, then clamped 1 and 0
        sync_ce(1);
        cfg_write(1, 7);
        capture(1, 11, cw, cev, rw);
        check("div7_clk", cw, 32'b10011100001);
        check("div7_ce", cev, 32'b00010000001);
        check("div7_ready", rw, 32'b00011111111);
        sync_ce(1);
        cfg_write(1, 1);
        capture(1, 10, cw, cev, rw);
        check("div1_clk", cw, 32'b1100001010);
        check("div1_ce", cev, 32'b0000001010);
        sync_ce(1);
        cfg_write(1, 0);
        capture(1, 5, cw, cev, rw);
        check("div0_clk", cw, 32'b01010);
        check("div0_ce", cev, 32'b01010);
        check("div0_ready", rw, 32'b01111);

        // back-to-back on ch1 stalls; ch0 accepts concurrently
        sync_ce(1);
        cfg_ch = 1'b1; cfg_div = 8'd5;
        #1;
        check("b2b_first_ready", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        @(negedge clk_in);
        #1;
        check("b2b_stall", 32'(cfg_ready), 32'd0);
        cfg_ch = 1'b0; cfg_div = 8'd3;
        #1;
        check("other_ch_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk_in);
        cfg_valid = 1'b0;
        #1;
        check("ch0_pending", 32'(cfg_ready), 32'd0);
        capture(1, 6, cw, cev, rw);
        check("div5_clk", cw, 32'b110001);
        check("div5_ce", cev, 32'b100001);
        wait_ready(0);
        sync_ce(0);
        capture(0, 4, cw, cev, rw);
        check("div3_clk", cw, 32'b1001);
        check("div3_ce", cev, 32'b1001);

        // en[0] drop during high phase at div 6: period completes, then idle
        cfg_write(0, 6);
        wait_ready(0);
        check("div6_start_ce", 32'(ce_out[0]), 32'd1);
        en = 2'b10;
        capture(0, 9, cw, cev, rw);
        check("drain_clk", cw, 32'b111000000);
        check("drain_ce", cev, 32'b100000000);
        en = 2'b11;
        capture(0, 2, cw, cev, rw);
        check("restart_clk", cw, 32'b01);
        check("restart_ce", cev, 32'b01);
        check("pre_reset_high", 32'(clk_out[0]), 32'd1);

        // asynchronous reset mid-period
        reset = 1'b1;
        #1;
        check("async_rst_clk", 32'(clk_out), 32'd0);
        check("async_rst_ce", 32'(ce_out), 32'd0);
        check("async_rst_locked", 32'(locked), 32'd0);
        check("async_rst_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        lock_and_default_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel clock divider and lock generator for the TTT design. It replaces the fixed divide-by-4 generator with NUM_CH independent channels, each with a runtime-programmable integer divisor. Each channel has a glitch-free enable and a one-cycle clock-enable strobe. All logic runs in the clk_in domain; downstream logic should prefer ce_out over clk_out as a clock.

## Interface
- NUM_CH, 2, number of divider channels (1..8)
- DIV_W, 8, divisor width in bits
- DIV_RESET, 4, divisor loaded into every channel at reset (≥2)
- LOCK_CYCLES, 256, clk_in cycles from reset release to locked
- clk_in  input  1  source clock; all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- en  input  NUM_CH  per-channel run enable
- cfg_valid  input  1  divisor update request
- cfg_ready  output  1  update accepted when cfg_valid & cfg_ready
- cfg_ch  input  max(1,$clog2(NUM_CH))  target channel
- cfg_div  input  DIV_W  new divisor
- clk_out  output  NUM_CH  divided clocks, registered
- ce_out  output  NUM_CH  one-cycle strobe coinciding with each clk_out rising edge
- locked  output  1  high once LOCK_CYCLES have elapsed; stays high until reset

## Operation
- Reset: clk_out=0, ce_out=0, locked=0, lock counter=0, every channel IDLE with cnt=0, div_act=DIV_RESET, no pending update, cfg_ready=1.
- Lock: the counter increments each cycle while locked=0. locked sets on the edge where the counter equals LOCK_CYCLES-1, then the counter freezes.
- Channel FSM, states IDLE and RUN:
  - IDLE: clk_out=0, ce_out=0. On an edge with locked=1 and en[i]=1: go to RUN, cnt<=0, clk_out<=1, ce_out<=1. Apply a pending divisor first, if one exists.
  - RUN, cnt≠div_act-1: cnt<=cnt+1, clk_out<=((cnt+1) < div_act>>1), ce_out<=0.
  - RUN, cnt=div_act-1 (period boundary):
    - en[i]=1: cnt<=0, clk_out<=1, ce_out<=1, load the pending divisor into div_act and clear the pending flag.
    - en[i]=0: go to IDLE with clk_out=0. The pending divisor is still loaded.
- Period is exactly div_act cycles. High time is floor(div_act/2), low time is the remainder. N=2 gives 1/1, N=3 gives 1/2.
- Deasserting en never truncates a period: the channel always completes its current period.
- Divisor clamp: a cfg_div value of 0 or 1 is stored as 2. Values are unsigned, full DIV_W range.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch).
  - On accept, pending[cfg_ch]<=1 and pend_div[cfg_ch]<=clamped cfg_div.
  - An update to an IDLE channel takes effect on its next start.
  - cfg_ch ≥ NUM_CH: accepted and discarded.
- Simultaneous accept and boundary on the same channel cannot occur, because pending=1 blocks accept and a boundary only clears an existing pending. The new value waits for the following boundary.
- Reset asserted mid-period: every output drops to 0 asynchronously, and the channel restarts only after a full re-lock.

## Timing
- locked is first high in the cycle after LOCK_CYCLES rising edges following reset release.
- The first clk_out/ce_out rise occurs 1 cycle after locked is sampled high with en[i]=1.
- Update latency: an accepted divisor takes effect at the next period boundary of that channel, from 1 to old div_act cycles later. cfg_ready for that channel returns high in the cycle after that boundary.
- ce_out[i] is high for exactly 1 cycle per period, in the same cycle as the clk_out rise.
- No combinational path from en or cfg inputs to clk_out, ce_out or locked. cfg_ready depends combinationally on cfg_ch only.

## Test plan
- Reset release with default parameters and en=all-1 -> locked rises after 256 cycles. Each channel then shows clk_out period 4 (2 high, 2 low), with ce_out pulses exactly 4 cycles apart.
- Channel 0 running at div 4, write cfg_div=10 at cnt=1 -> the current period still completes 4 cycles and later periods are 10 (5/5). cfg_ready stays low from the accept until the cycle after the boundary.
- Write cfg_div=7 to channel 1 -> period 7 (3 high, 4 low). Write cfg_div=1, then 0 -> period 2 (1/1) in both cases.
- Deassert en[0] during the high phase at div 6 -> the full 6-cycle period completes, then clk_out=0 and ce_out=0. Re-assert en[0] -> a restart pulse appears 1 cycle later.
- Back-to-back cfg_valid to the same channel -> the second request stalls (cfg_ready=0) until the boundary. A concurrent request to the other channel is accepted immediately.
- Assert reset mid-period -> all outputs go to 0 immediately and locked=0. After release, the full 256-cycle lock repeats and divisors return to DIV_RESET.
